instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Program counter and instruction fetch stage for the single-cycle CPU; sits directly upstream of the control unit. It holds the PC, fetches from instruction memory over a req/ack handshake, and presents the latched instruction and its Opcode field for exactly one execute cycle. It consumes the control unit's PCWre/PCSrc to compute the next PC or halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
CLK  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = PC forced to RESET_PC, FSM to IDLE).
PCWre  input  1  from control unit; 1 = advance PC, 0 = halt.
PCSrc  input  2  from control unit; next-PC select.
ext_imm  input  32  sign/zero-extended immediate from extender.
rs_data  input  32  register rs read data (jr target).
jmp_addr  input  26  Instr[25:0] jump field.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address (= PC while requesting).
imem_ack  input  1  memory returns data this cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
PC  output  32  current PC.
Instr  output  32  latched instruction.
Opcode  output  6  Instr[31:26].
instr_valid  output  1  1 during the single EXEC cycle.
halted  output  1  1 in HALT state.
misalign_err  output  1  sticky; jr target had nonzero bits [1:0].

Behaviour:
- Reset (async, reset=0): PC=RESET_PC, Instr=0, Opcode=0, instr_valid=0, imem_req=0, halted=0, misalign_err=0, state=IDLE. Takes effect immediately, including mid-fetch (imem_req drops in the same cycle).
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=PC. Wait indefinitely for imem_ack. On ack: Instr<=imem_rdata, -> EXEC. A same-cycle ack with req yields minimum fetch latency of 1 cycle.
- EXEC: exactly one cycle, instr_valid=1, imem_req=0. At the clock edge ending EXEC: if PCWre=1, PC<=next_pc and -> FETCH; if PCWre=0, PC unchanged, -> HALT.
- HALT: halted=1, imem_req=0, instr_valid=0; leaves only via reset.
- imem_ack outside FETCH is ignored; Instr holds.
- next_pc, with pc4=PC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0):
  00: pc4
  01: pc4 + (ext_imm<<2), 32-bit wrap, carry discarded
  10: {rs_data[31:2],2'b00}; if rs_data[1:0]!=0 set misalign_err (sticky until reset)
  11: {pc4[31:28], jmp_addr, 2'b00}
- PCSrc/PCWre are sampled only at the end of EXEC; values in other states have no effect.
- Instr/Opcode remain stable from EXEC through the next FETCH until the next ack.

Optional Feature:
Macro FETCH_RETIRE_CNT_EN. When defined: extra output retired_cnt[31:0], reset to 0, increments by 1 at the end of every EXEC cycle (including the one that halts), wraps 32'hFFFF_FFFF -> 0, frozen in HALT. When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, imem_ack tied 1, PCSrc=00, PCWre=1 -> imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; Opcode equals rdata[31:26].
- Branch: PC=0x10, PCSrc=01, ext_imm=32'hFFFF_FFFE -> next imem_addr=0x0C; ext_imm=3 -> 0x20.
- Jump: PC=0x3000_0000, PCSrc=11, jmp_addr=26'h000_0040 -> imem_addr=0x3000_0100. jr: rs_data=0x0000_0106, PCSrc=10 -> imem_addr=0x104, misalign_err=1 and held.
- Halt: PCWre=0 in EXEC -> halted=1, imem_req=0, PC unchanged for 20 cycles despite toggling imem_ack/PCSrc.
- Slow memory: ack after 5 wait cycles -> imem_req high and imem_addr stable all 5 cycles, Instr updates only on ack; reset asserted in wait cycle 3 -> imem_req=0 immediately, PC=RESET_PC.
- Wrap: PC=0xFFFF_FFFC, PCSrc=00 -> next imem_addr=0; with FETCH_RETIRE_CNT_EN, retired_cnt equals number of instr_valid pulses.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// PC register and instruction fetch stage: IDLE -> FETCH (req/ack) -> EXEC -> FETCH/HALT.
// Optional retired-instruction counter enabled by defining FETCH_RETIRE_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    input  logic [25:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic        instr_valid,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc4;
    logic [31:0] brOff;
    logic [31:0] nextPc;
    logic        jrMisalign;

    assign pc4   = PC + 32'd4;
    assign brOff = ext_imm << 2;

    always_comb begin
        nextPc = pc4;
        case (PCSrc)
            2'b00: nextPc = pc4;
            2'b01: nextPc = pc4 + brOff;
            2'b10: nextPc = {rs_data[31:2], 2'b00};
            2'b11: nextPc = {pc4[31:28], jmp_addr, 2'b00};
            default: nextPc = pc4;
        endcase
    end

    assign jrMisalign = (PCSrc == 2'b10) && (rs_data[1:0] != 2'b00);

    // Outputs decode straight from state so an async reset drops imem_req at once.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = PC;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);
    assign Opcode      = Instr[31:26];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            PC           <= RESET_PC;
            Instr        <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        Instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (PCWre) begin
                        PC    <= nextPc;
                        state <= FETCH;
                        if (jrMisalign) misalign_err <= 1'b1;
                    end else begin
                        state <= HALT;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    // Counts every completed EXEC, including the one that halts.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) retired_cnt <= 32'd0;
        else if (state == EXEC) retired_cnt <= retired_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and instruction
// words are queued as stimulus is driven and checked when the DUT presents them.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] ext_imm, rs_data;
    logic [25:0] jmp_addr;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC, Instr;
    logic [5:0]  Opcode;
    logic        instr_valid, halted, misalign_err;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    instr_fetch_unit dut (
        .CLK(CLK), .reset(reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .ext_imm(ext_imm), .rs_data(rs_data), .jmp_addr(jmp_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .PC(PC), .Instr(Instr), .Opcode(Opcode),
        .instr_valid(instr_valid), .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int nVec = 0;
    int nErr = 0;
    int nRetired = 0;
    logic expMis = 1'b0;
    logic [31:0] addrQ[$];
    logic [31:0] instrQ[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Junk control values while not in EXEC; the DUT must ignore them.
    task automatic junkCtl();
        PCWre = 1'b0; PCSrc = 2'b10; rs_data = 32'h0000_0003;
        ext_imm = 32'h1234_5678; jmp_addr = 26'h3FF_FFFF;
    endtask

    task automatic waitReq();
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("reqSeen", {31'd0, imem_req}, 32'd1);
    endtask

    // One full fetch/exec; expNext is the fetch address expected after EXEC.
    task automatic fetchOne(input int waits, input logic [31:0] word, input logic wre,
                            input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs,
                            input logic [25:0] jmp, input logic [31:0] expNext, input logic mis);
        logic [31:0] expA, held, expW, pcNow;
        waitReq();
        expA = addrQ.size() != 0 ? addrQ.pop_front() : 32'hDEAD_BEEF;
        chk("fetchAddr", imem_addr, expA);
        held = Instr;
        junkCtl();
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge CLK);
            chk("waitReq", {31'd0, imem_req}, 32'd1);
            chk("waitAddr", imem_addr, expA);
            chk("waitInstr", Instr, held);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        instrQ.push_back(word);
        @(negedge CLK);
        imem_ack = 1'b0;
        imem_rdata = ~word;
        chk("execValid", {31'd0, instr_valid}, 32'd1);
        chk("execReq", {31'd0, imem_req}, 32'd0);
        expW = instrQ.size() != 0 ? instrQ.pop_front() : 32'hDEAD_BEEF;
        chk("instr", Instr, expW);
        chk("opcode", {26'd0, Opcode}, {26'd0, expW[31:26]});
        nRetired++;
        pcNow = PC;
        PCWre = wre; PCSrc = src; ext_imm = imm; rs_data = rs; jmp_addr = jmp;
        if (wre) addrQ.push_back(expNext);
        if (mis) expMis = 1'b1;
        @(negedge CLK);
        junkCtl();
        chk("misalign", {31'd0, misalign_err}, {31'd0, expMis});
        chk("notValid", {31'd0, instr_valid}, 32'd0);
        if (wre) chk("pcNext", PC, expNext);
        else begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("haltPc", PC, pcNow);
        end
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "Pc"}, PC, 32'd0);
        chk({tag, "Instr"}, Instr, 32'd0);
        chk({tag, "Opcode"}, {26'd0, Opcode}, 32'd0);
        chk({tag, "Valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "Req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "Halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "Mis"}, {31'd0, misalign_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] heldInstr;
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        junkCtl();
        @(negedge CLK);
        @(negedge CLK);
        checkResetState("rst");
        reset = 1'b1;
        addrQ.push_back(32'h0000_0000);

        // Sequential, branch, jr, jump and misaligned jr
        fetchOne(0, 32'h2001_0001, 1, 2'b00, 0, 0, 0, 32'h0000_0004, 0);
        fetchOne(0, 32'h8C22_0004, 1, 2'b00, 0, 0, 0, 32'h0000_0008, 0);
        fetchOne(0, 32'h0060_0008, 1, 2'b10, 0, 32'h0000_0010, 0, 32'h0000_0010, 0);
        fetchOne(0, 32'h1000_FFFE, 1, 2'b01, 32'hFFFF_FFFE, 0, 0, 32'h0000_000C, 0);
        fetchOne(0, 32'h0060_0008, 1, 2'b10, 0, 32'h0000_0010, 0, 32'h0000_0010, 0);
        fetchOne(0, 32'h1400_0003, 1, 2'b01, 32'h0000_0003, 0, 0, 32'h0000_0020, 0);
        fetchOne(0, 32'h0060_0008, 1, 2'b10, 0, 32'h3000_0000, 0, 32'h3000_0000, 0);
        fetchOne(0, 32'h0800_0040, 1, 2'b11, 0, 0, 26'h000_0040, 32'h3000_0100, 0);
        fetchOne(0, 32'h00A0_0008, 1, 2'b10, 0, 32'h0000_0106, 0, 32'h0000_0104, 1);
        // Slow memory, then jr to top of address space and wrap
        fetchOne(5, 32'hAC43_0010, 1, 2'b10, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0);
        fetchOne(2, 32'h3C05_ABCD, 1, 2'b00, 0, 0, 0, 32'h0000_0000, 0);
        fetchOne(0, 32'h2002_0002, 1, 2'b00, 0, 0, 0, 32'h0000_0004, 0);

        // Reset in the third wait cycle of a stalled fetch
        waitReq();
        chk("abortAddr", imem_addr, addrQ.size() != 0 ? addrQ.pop_front() : 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("abortReq", {31'd0, imem_req}, 32'd0);
        chk("abortPc", PC, 32'h0000_0000);
        @(negedge CLK);
        checkResetState("abort");
        nRetired = 0;
        expMis = 1'b0;
        reset = 1'b1;
        addrQ.push_back(32'h0000_0000);

        fetchOne(1, 32'h0000_000D, 0, 2'b01, 32'h0000_0010, 0, 0, 32'h0000_0000, 0);
        heldInstr = 32'h0000_000D;
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            imem_rdata = 32'hFFFF_0000 | i;
            PCSrc = i[1:0];
            PCWre = 1'b1;
            @(negedge CLK);
            chk("haltFlag", {31'd0, halted}, 32'd1);
            chk("haltReq", {31'd0, imem_req}, 32'd0);
            chk("haltValid", {31'd0, instr_valid}, 32'd0);
            chk("haltPcHold", PC, 32'h0000_0000);
            chk("haltInstr", Instr, heldInstr);
        end
`ifdef FETCH_RETIRE_CNT_EN
        chk("retiredCnt", retired_cnt, nRetired);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
